mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch port (IF) and the data-memory port (DM) of the 5-stage pipeline.
- Serialises requests through a grant state machine and returns a one-cycle registered acknowledge to the winning requester.
- Drives a stall to the pipeline (PC write / IF-ID hold, same path as the hazard detector) while any request is outstanding.
- DM has priority (older instruction); a starvation counter guarantees IF progress.

Parameters:
- ADDR_W, 32, address width on every port
- DATA_W, 32, data width on every port
- STARVE_MAX, 3, consecutive DM grants taken while IF is waiting before IF is forced to win (1..15)

Ports:
- clk_i in 1: clock
- rst_i in 1: synchronous active-high reset
- if_req_i in 1: IF read request; held until if_ack_o
- if_addr_i in ADDR_W: IF address
- if_data_o out DATA_W: fetched word; valid when if_ack_o=1
- if_ack_o out 1: one-cycle IF completion pulse
- dm_req_i in 1: DM request; held until dm_ack_o
- dm_we_i in 1: 1 = write, 0 = read
- dm_addr_i in ADDR_W: DM address
- dm_wdata_i in DATA_W: DM write data
- dm_rdata_o out DATA_W: DM read word; valid when dm_ack_o=1 after a read
- dm_ack_o out 1: one-cycle DM completion pulse
- stall_o out 1: pipeline freeze
- mem_req_o out 1: backing-memory request
- mem_we_o out 1: backing-memory write enable
- mem_addr_o out ADDR_W: backing-memory address
- mem_wdata_o out DATA_W: backing-memory write data
- mem_rdata_i in DATA_W: backing-memory read data; valid with mem_ready_i
- mem_ready_i in 1: backing-memory completion; one cycle per transaction, any latency >= 1 cycle after mem_req_o rises
- stall_cnt_o out 16: saturating count of stall_o-high cycles

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - State goes to IDLE.
  - Every registered output goes to 0: acks, mem_*_o, if_data_o, dm_rdata_o, stall_cnt_o.
  - starve_cnt goes to 0.
  - Any in-flight transaction is abandoned; no ack is issued for it.
  - mem_ready_i arriving after reset is ignored.
- States: IDLE, BUSY_IF, BUSY_DM, ACK.
- IDLE:
  - If dm_req_i=1 and (if_req_i=0 or starve_cnt<STARVE_MAX): go to BUSY_DM.
  - Else if if_req_i=1: go to BUSY_IF.
  - Else: stay in IDLE.
  - On any grant, latch address, we and wdata into the mem_*_o registers and set mem_req_o=1, all at the same edge.
  - IF grants always have mem_we_o=0.
- BUSY_x:
  - mem_* outputs are held stable.
  - On mem_ready_i=1: clear mem_req_o and mem_we_o and go to ACK.
  - BUSY_IF ready: if_data_o <= mem_rdata_i and if_ack_o <= 1.
  - BUSY_DM ready, read: dm_rdata_o <= mem_rdata_i and dm_ack_o <= 1.
  - BUSY_DM ready, write: dm_ack_o <= 1; dm_rdata_o unchanged.
- ACK:
  - The ack is high for exactly this one cycle; no grant is made.
  - Next state is IDLE, and acks clear.
  - The requester's stale req during ACK is therefore never re-granted.
- Minimum occupancy per transaction is 1 (grant) + L (memory latency) + 1 (ACK) cycles.
- if_data_o and dm_rdata_o hold their last captured value otherwise.
- starve_cnt updates only on IDLE grants:
  - DM granted while if_req_i=1: increment, saturating at STARVE_MAX.
  - IF granted: clear to 0.
  - DM granted with if_req_i=0: unchanged.
- Requester withdraws req while its transaction is BUSY: the transaction still completes and the ack is still pulsed.
- mem_ready_i in IDLE or ACK is ignored.
- stall_o is combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at 16'hFFFF.
- Simultaneous first requests after reset: DM wins, since starve_cnt=0<STARVE_MAX.

Test Plan:
- Reset mid-BUSY_DM, then mem_ready_i=1 on the next cycle -> no dm_ack_o; mem_req_o=0; state IDLE; stall_cnt_o=0.
- IF only: if_req_i=1, if_addr_i=32'h0000_0010; memory answers 2 cycles after mem_req_o with 32'h8C01_0004 -> mem_addr_o=32'h10, mem_we_o=0; if_ack_o pulses once with if_data_o=32'h8C01_0004, 4 cycles after request; stall_o=1 until the ack cycle.
- DM write: dm_req_i=1, dm_we_i=1, dm_addr_i=32'h20, dm_wdata_i=32'hDEAD_BEEF -> mem_we_o=1, mem_wdata_o=32'hDEAD_BEEF; dm_ack_o pulses; dm_rdata_o unchanged.
- Both requesting continuously, 1-cycle memory, STARVE_MAX=3 -> grant order DM, DM, DM, IF, DM, DM, DM, IF; no two acks in the same cycle.
- DM read while IF idle: dm_addr_i=32'h40, memory returns 32'h0000_0005 -> dm_rdata_o=5 on dm_ack_o; if_ack_o stays 0; starve_cnt stays 0.
- Hold stall_o high for 70000 cycles (memory never ready) -> stall_cnt_o saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/DM requester ports, the backing-memory port and the stall outputs.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline/memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ack_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;

    logic              stall_o;
    logic [15:0]       stall_cnt_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ready_i,
        output if_data_o, if_ack_o, dm_rdata_o, dm_ack_o,
        output stall_o, stall_cnt_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ready_i,
        input  if_data_o, if_ack_o, dm_rdata_o, dm_ack_o,
        input  stall_o, stall_cnt_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and DM requests onto one single-port memory: DM-first with a starvation
// limit for IF, registered one-cycle acks, and a pipeline stall while a request is pending.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, ACK} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic              grant_dm, grant_if, done_if, done_dm;
    logic              if_ack_q, dm_ack_q, mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_data_q, dm_rdata_q;
    logic [15:0]       stall_cnt_q;
    logic [3:0]        starve_q;
    logic              stall;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] sat_inc_starve(input logic [3:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_dm)      state_d = BUSY_DM;
                else if (grant_if) state_d = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: if (bus.mem_ready_i) state_d = ACK;
            ACK:              state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // IF only beats a waiting DM once DM has taken STARVE_MAX grants in a row over it.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        done_if  = 1'b0;
        done_dm  = 1'b0;
        case (state_q)
            IDLE: begin
                grant_dm = bus.dm_req_i && (!bus.if_req_i || (starve_q < STARVE_LIM));
                grant_if = !grant_dm && bus.if_req_i;
            end
            BUSY_IF: done_if = bus.mem_ready_i;
            BUSY_DM: done_dm = bus.mem_ready_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
            stall_cnt_q <= '0;
            starve_q    <= '0;
        end else begin
            if_ack_q <= done_if;
            dm_ack_q <= done_dm;

            if (grant_dm) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.dm_we_i;
                mem_addr_q  <= bus.dm_addr_i;
                mem_wdata_q <= bus.dm_wdata_i;
            end else if (grant_if) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= bus.if_addr_i;
            end else if (done_if || done_dm) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
            end

            if (done_if)              if_data_q  <= bus.mem_rdata_i;
            if (done_dm && !mem_we_q) dm_rdata_q <= bus.mem_rdata_i;

            if (grant_dm && bus.if_req_i) starve_q <= sat_inc_starve(starve_q);
            else if (grant_if)            starve_q <= '0;

            if (stall) stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    assign stall = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);

    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.dm_ack_o    = dm_ack_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
endmodule
